// File: rtl/bin_maxpool2x2.sv
`default_nettype none
// ============================================================================
//  Module   : bin_maxpool2x2
//  Purpose  : Binary 2x2 / stride-2 max-pool stage. Walks the feature maps
//             that the conv engine left in the result SRAM, ORs every 2x2
//             pixel block and writes the pooled maps, each with its header,
//             into the next-layer SRAM. The pooled stream ends with 0x00FF.
//  Ports    : clk, reset_b                 - clock, async active-low reset
//             pool_run / pool_busy         - start pulse / job-in-progress
//             pool_sram_read_address       - input SRAM address
//             sram_pool_read_data          - data valid one cycle later
//             pool_sram_write_address/data - output SRAM write port
//             pool_sram_write_enable       - one word written per high cycle
//  Revision : 1.0 - initial release
// ============================================================================
module bin_maxpool2x2 #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 16,
   parameter int MAX_DIM = 14
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              pool_run,
   output logic              pool_busy,
   output logic [ADDR_W-1:0] pool_sram_read_address,
   input  logic [DATA_W-1:0] sram_pool_read_data,
   output logic [ADDR_W-1:0] pool_sram_write_address,
   output logic [DATA_W-1:0] pool_sram_write_data,
   output logic              pool_sram_write_enable
);

   localparam logic [2:0] c_ST_IDLE = 3'd0;
   localparam logic [2:0] c_ST_HDR  = 3'd1;
   localparam logic [2:0] c_ST_EVEN = 3'd2;
   localparam logic [2:0] c_ST_ODD  = 3'd3;
   localparam logic [2:0] c_ST_TERM = 3'd4;

   localparam logic [DATA_W-1:0] c_TERM_WORD = DATA_W'('hFF);
   localparam logic [DATA_W-1:0] c_MIN_DIM   = DATA_W'(2);
   localparam logic [DATA_W-1:0] c_MAX_DIM   = DATA_W'(MAX_DIM);

   logic [2:0]        r_state;
   logic              r_prime;     // first HDR cycle: address 0 just issued, no data yet
   logic              r_run_q;     // previous pool_run, so a held run starts one job only
   logic              r_busy;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_we;
   logic [DATA_W-1:0] r_hold;      // even row of the current pair
   logic [2:0]        r_half_m1;   // M/2 - 1 of the current map
   logic [2:0]        r_pair;      // row-pair index within the map

   logic              w_legal;
   logic [2:0]        w_half_m1;
   logic [DATA_W-1:0] w_vert;
   logic [DATA_W-1:0] w_pool;

   // Header is legal only as an even value in 2..MAX_DIM over the full word.
   assign w_legal   = (sram_pool_read_data[0] == 1'b0) &&
                      (sram_pool_read_data >= c_MIN_DIM) &&
                      (sram_pool_read_data <= c_MAX_DIM);
   assign w_half_m1 = sram_pool_read_data[3:1] - 3'd1;

   // Vertical OR of the row pair, then horizontal OR of adjacent columns.
   // Columns beyond M/2 are forced to 0, which also drops input bits >= M.
   assign w_vert = r_hold | sram_pool_read_data;

   always_comb begin
      w_pool = '0;
      for (int j = 0; j < DATA_W / 2; j++) begin
         w_pool[j] = (w_vert[2*j] | w_vert[2*j+1]) && (j <= int'(r_half_m1));
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state   <= c_ST_IDLE;
         r_prime   <= 1'b0;
         r_run_q   <= 1'b0;
         r_busy    <= 1'b0;
         r_rd_addr <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_we      <= 1'b0;
         r_hold    <= '0;
         r_half_m1 <= '0;
         r_pair    <= '0;
      end else begin
         r_run_q <= pool_run;
         r_we    <= 1'b0;
         if (r_we) begin
            r_wr_addr <= r_wr_addr + 1'b1;
         end
         if (r_state != c_ST_IDLE) begin
            r_rd_addr <= r_rd_addr + 1'b1;
         end

         case (r_state)
            c_ST_IDLE: begin
               if (pool_run && !r_run_q) begin
                  r_state   <= c_ST_HDR;
                  r_busy    <= 1'b1;
                  r_prime   <= 1'b1;
                  r_rd_addr <= '0;
                  r_wr_addr <= '0;
                  r_pair    <= '0;
               end
            end
            c_ST_HDR: begin
               if (r_prime) begin
                  r_prime <= 1'b0;
               end else if (w_legal) begin
                  r_half_m1 <= w_half_m1;
                  r_pair    <= '0;
                  r_we      <= 1'b1;
                  r_wr_data <= sram_pool_read_data >> 1;
                  r_state   <= c_ST_EVEN;
               end else begin
                  r_we      <= 1'b1;
                  r_wr_data <= c_TERM_WORD;
                  r_state   <= c_ST_TERM;
               end
            end
            c_ST_EVEN: begin
               r_hold  <= sram_pool_read_data;
               r_state <= c_ST_ODD;
            end
            c_ST_ODD: begin
               r_we      <= 1'b1;
               r_wr_data <= w_pool;
               r_pair    <= r_pair + 3'd1;
               r_state   <= (r_pair == r_half_m1) ? c_ST_HDR : c_ST_EVEN;
            end
            c_ST_TERM: begin
               // Terminator write is on the bus this cycle.
               r_busy  <= 1'b0;
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign pool_busy               = r_busy;
   assign pool_sram_read_address  = r_rd_addr;
   assign pool_sram_write_address = r_wr_addr;
   assign pool_sram_write_data    = r_wr_data;
   assign pool_sram_write_enable  = r_we;

endmodule
`default_nettype wire

// File: tb/tb_bin_maxpool2x2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_maxpool2x2
//  Purpose  : Self-checking bench for bin_maxpool2x2. An SRAM model feeds the
//             DUT; a map-level reference builds the expected write stream,
//             which a monitor compares on every write cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_maxpool2x2;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 16;
   localparam int MAX_DIM = 14;

   logic              clk = 1'b0;
   logic              reset_b = 1'b0;
   logic              pool_run = 1'b0;
   logic              pool_busy;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data = '0;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   bin_maxpool2x2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DIM(MAX_DIM)) dut (
      .clk                     (clk),
      .reset_b                 (reset_b),
      .pool_run                (pool_run),
      .pool_busy               (pool_busy),
      .pool_sram_read_address  (rd_addr),
      .sram_pool_read_data     (rd_data),
      .pool_sram_write_address (wr_addr),
      .pool_sram_write_data    (wr_data),
      .pool_sram_write_enable  (wr_en)
   );

   always #5 clk = ~clk;

   // Input SRAM: one-cycle read latency.
   always @(posedge clk) rd_data <= mem[rd_addr];

   int                n_checks = 0;
   int                n_err    = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] got_q[$];
   logic [DATA_W-1:0] ref_q[$];
   int                exp_idx = 0;
   bit                chk_en  = 1'b0;
   bit                prev_busy = 1'b0;
   logic [ADDR_W-1:0] prev_ra = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Write-stream and read-address monitor.
   always @(negedge clk) begin
      if (chk_en) begin
         if (wr_en) begin
            got_q.push_back(wr_data);
            if (exp_idx < exp_q.size()) begin
               check("wr_data", {16'h0, wr_data}, {16'h0, exp_q[exp_idx]});
               check("wr_addr", {20'h0, wr_addr}, exp_idx);
            end else begin
               n_checks++;
               n_err++;
               $display("FAIL extra_write: got data 0x%0h at 0x%0h, expected no write", wr_data, wr_addr);
            end
            exp_idx++;
         end
         if (pool_busy) begin
            check("rd_addr", {20'h0, rd_addr}, prev_busy ? int'(prev_ra) + 1 : 0);
         end
      end
      prev_busy = pool_busy;
      prev_ra   = rd_addr;
   end

   // Reference: parse maps from memory and pool them pixel by pixel.
   function automatic bit pix(input int base, input int r, input int c);
      logic [DATA_W-1:0] row;
      row = mem[base + 1 + r];
      return row[c];
   endfunction

   task automatic build_model();
      int a;
      int h;
      logic [DATA_W-1:0] row;
      exp_q.delete();
      a = 0;
      forever begin
         h = int'(mem[a]);
         if ((h % 2 == 0) && (h >= 2) && (h <= MAX_DIM)) begin
            exp_q.push_back(DATA_W'(h / 2));
            for (int i = 0; i < h / 2; i++) begin
               row = '0;
               for (int j = 0; j < h / 2; j++) begin
                  row[j] = pix(a, 2*i, 2*j) | pix(a, 2*i, 2*j+1) |
                           pix(a, 2*i+1, 2*j) | pix(a, 2*i+1, 2*j+1);
               end
               exp_q.push_back(row);
            end
            a = a + h + 1;
         end else begin
            exp_q.push_back(DATA_W'('hFF));
            break;
         end
      end
   endtask

   // Random maps; first_m = 0 picks a random legal dimension for map 0 too.
   task automatic gen_random(input int nmaps, input int first_m);
      int a;
      int m;
      logic [DATA_W-1:0] bad [6];
      bad = '{16'h0000, 16'h0001, 16'h0009, 16'h0010, 16'h000F, 16'h0108};
      a = 0;
      for (int k = 0; k < nmaps; k++) begin
         m = (k == 0 && first_m != 0) ? first_m : 2 * int'($urandom_range(1, MAX_DIM / 2));
         mem[a] = DATA_W'(m);
         a++;
         for (int r = 0; r < m; r++) begin
            mem[a] = DATA_W'($urandom) & DATA_W'($urandom);
            a++;
         end
      end
      mem[a] = ($urandom_range(0, 1) == 0) ? DATA_W'('hFF) : bad[$urandom_range(0, 5)];
   endtask

   task automatic start_job();
      build_model();
      got_q.delete();
      exp_idx = 0;
      chk_en  = 1'b1;
   endtask

   task automatic run_job(input bit hold_run, input bit extra_pulse);
      int cyc;
      start_job();
      @(negedge clk) pool_run = 1'b1;
      @(negedge clk) if (!hold_run) pool_run = 1'b0;
      cyc = 0;
      while (pool_busy && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (extra_pulse && cyc == 7) pool_run = 1'b1;
         if (extra_pulse && cyc == 8) pool_run = 1'b0;
      end
      if (cyc >= 3000) begin
         n_checks++;
         n_err++;
         $display("FAIL job_timeout: got busy after %0d cycles, expected completion", cyc);
      end
      check("busy_done", {31'h0, pool_busy}, 0);
      check("write_count", exp_idx, exp_q.size());
      if (hold_run) begin
         repeat (5) @(negedge clk);
         check("held_run_one_job", {31'h0, pool_busy}, 0);
         pool_run = 1'b0;
      end
      chk_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, {31'h0, pool_busy}, 0);
      check({tag, "_rd_addr"}, {20'h0, rd_addr}, 0);
      check({tag, "_wr_addr"}, {20'h0, wr_addr}, 0);
      check({tag, "_wr_data"}, {16'h0, wr_data}, 0);
      check({tag, "_wr_en"}, {31'h0, wr_en}, 0);
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset_b = 1'b1;
      @(negedge clk);

      // Single map, M=8, alternating rows
      mem[0] = 16'h0008;
      for (int r = 0; r < 8; r++) mem[1 + r] = (r % 2 == 0) ? 16'h00AA : 16'h0000;
      mem[9] = 16'h00FF;
      run_job(1'b0, 1'b0);
      check("single_size", got_q.size(), 6);
      if (got_q.size() == 6) begin
         check("single_hdr", {16'h0, got_q[0]}, 32'h4);
         for (int i = 1; i <= 4; i++) check("single_row", {16'h0, got_q[i]}, 32'hF);
         check("single_term", {16'h0, got_q[5]}, 32'hFF);
      end

      // Pixel isolation, M=14, only (13,13)
      mem[0] = 16'h000E;
      for (int r = 0; r < 14; r++) mem[1 + r] = (r == 13) ? 16'h2000 : 16'h0000;
      mem[15] = 16'h00FF;
      run_job(1'b0, 1'b0);
      check("iso_size", got_q.size(), 9);
      if (got_q.size() == 9) begin
         check("iso_hdr", {16'h0, got_q[0]}, 32'h7);
         check("iso_row0", {16'h0, got_q[1]}, 32'h0);
         check("iso_row5", {16'h0, got_q[6]}, 32'h0);
         check("iso_row6", {16'h0, got_q[7]}, 32'h40);
      end

      // Back-to-back: M=10 all ones, M=14 all zeros
      mem[0] = 16'h000A;
      for (int r = 0; r < 10; r++) mem[1 + r] = 16'hFFFF;
      mem[11] = 16'h000E;
      for (int r = 0; r < 14; r++) mem[12 + r] = 16'h0000;
      mem[26] = 16'h00FF;
      run_job(1'b0, 1'b0);
      check("b2b_size", got_q.size(), 15);
      if (got_q.size() == 15) begin
         check("b2b_hdr0", {16'h0, got_q[0]}, 32'h5);
         check("b2b_row", {16'h0, got_q[3]}, 32'h1F);
         check("b2b_hdr1", {16'h0, got_q[6]}, 32'h7);
         check("b2b_zero", {16'h0, got_q[10]}, 32'h0);
         check("b2b_term", {16'h0, got_q[14]}, 32'hFF);
      end

      // Illegal first header
      mem[0] = 16'h0009;
      run_job(1'b0, 1'b0);
      check("illegal_size", got_q.size(), 1);
      if (got_q.size() == 1) check("illegal_term", {16'h0, got_q[0]}, 32'hFF);

      // Reset abort in the 3rd row pair of an M=14 map
      gen_random(1, 14);
      start_job();
      @(negedge clk) pool_run = 1'b1;
      @(negedge clk) pool_run = 1'b0;
      cyc = 0;
      while (exp_idx < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_reached", exp_idx, 3);
      chk_en = 1'b0;
      @(posedge clk);
      #2 reset_b = 1'b0;
      #1 check_outputs_zero("abort");
      repeat (2) @(negedge clk);
      check("abort_no_write", {31'h0, wr_en}, 0);
      reset_b = 1'b1;
      @(negedge clk);
      gen_random(2, 0);
      run_job(1'b0, 1'b0);

      // Run while busy: identical stream with and without an extra pulse
      gen_random(3, 14);
      run_job(1'b0, 1'b0);
      ref_q = got_q;
      run_job(1'b0, 1'b1);
      check("rerun_size", got_q.size(), ref_q.size());
      for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
         check("rerun_word", {16'h0, got_q[i]}, {16'h0, ref_q[i]});
      end

      // Run held high across the whole job
      gen_random(2, 0);
      run_job(1'b1, 1'b0);

      // Random jobs
      for (int t = 0; t < 10; t++) begin
         gen_random(int'($urandom_range(1, 5)), 0);
         run_job(1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bin_maxpool2x2.md
Name: bin_maxpool2x2

Overview:
- Binary 2x2/stride-2 max-pool stage sitting directly downstream of the binary 3x3 convolution engine.
- Reads conv feature maps from the result SRAM and pools each map by OR-ing every 2x2 pixel block.
- Writes the pooled maps, with headers, into a second SRAM for the next layer.
- Uses the same run/busy handshake and 1-cycle-latency SRAM interface as the conv engine.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM word width; one word holds one image row.
- MAX_DIM, 14, largest legal input map dimension M.

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous active-low reset
- pool_run  in  1  start pulse; sampled only in IDLE
- pool_busy  out  1  high from the cycle after an accepted start until the job completes
- pool_sram_read_address  out  ADDR_W  input-map SRAM read address
- sram_pool_read_data  in  DATA_W  read data; valid the cycle after the address is presented
- pool_sram_write_address  out  ADDR_W  output SRAM write address
- pool_sram_write_data  out  DATA_W  output SRAM write data
- pool_sram_write_enable  out  1  write strobe; one word is written per high cycle

Behaviour:
- Reset: reset_b is asynchronous and active-low; clock is clk. All outputs reset to 0, FSM goes to IDLE. Reset mid-job aborts immediately and no further writes occur.
- Input format:
  - Maps are stored contiguously from address 0.
  - Each map is a header word holding M, followed by M row words.
  - Row r, bit c = pixel (r,c). Bits at positions >= M are ignored.
  - Header 0x00FF terminates the job.
  - Legal M: even, 2..MAX_DIM. Any other header value, including 0, is treated as a terminator.
- Output format:
  - Words are written contiguously from address 0.
  - Each map is a header word of value M/2, then M/2 pooled rows.
  - Pooled row i, bit j = in[2i][2j] | in[2i][2j+1] | in[2i+1][2j] | in[2i+1][2j+1], for j < M/2.
  - Bits at positions >= M/2 are written as 0.
  - After the last map, the terminator word 0x00FF is written.
- FSM states: IDLE, HDR, EVEN, ODD, TERM.
  - IDLE -> HDR on pool_run. Read address is set to 0 in the same edge; pool_busy=1 from the next cycle.
  - HDR: captures the header word. Legal header -> EVEN. Illegal header or terminator -> TERM.
  - EVEN: captures row 2i into a holding register.
  - ODD: captures row 2i+1 and ORs it with the held row. Then goes to EVEN, or to HDR after the last row pair.
  - TERM: writes 0x00FF, then returns to IDLE; pool_busy drops at the next edge.
- Throughput: one read is issued every cycle while busy; the read address increments by 1 each cycle with no bubbles between maps.
- A map of dimension M occupies M+1 read cycles.
- Write timing:
  - The header write asserts the cycle after the header data is captured.
  - A pooled-row write asserts the cycle after the ODD capture.
  - The write address increments after each write.
- The write address never wraps within a job; behaviour past address 2^ADDR_W - 1 is undefined.
- Address and counters reset to 0 at each new accepted pool_run.
- pool_run while busy is ignored. pool_run held high in IDLE starts exactly one job.
- Row-pair counter: 3 bits, compared against M/2 - 1. M is latched only at HDR.

Test Plan:
- Single map:
  - Stimulus: M=8 (header 0x0008), rows alternating 0x00AA/0x0000, then 0x00FF.
  - Required: writes 0x0004 and 4x 0x000F at addresses 0..4, then 0x00FF at address 5; pool_busy low afterwards.
- Pixel isolation:
  - Stimulus: M=14, only pixel (13,13) set.
  - Required: pooled rows 0..5 = 0, row 6 = 0x0040, header 0x0007.
- Back-to-back maps:
  - Stimulus: M=10 map (all ones) followed directly by an M=14 map (all zeros), then terminator.
  - Required: 0x0005, 5x 0x001F, 0x0007, 7x 0x0000, 0x00FF, on contiguous addresses; reads issued with no idle cycle.
- Illegal header:
  - Stimulus: first header 0x0009.
  - Required: only the word 0x00FF is written, at address 0; job ends.
- Reset abort:
  - Stimulus: assert reset_b low in the middle of the 3rd row pair of an M=14 map.
  - Required: all outputs 0 the same cycle. A subsequent pool_run restarts correctly from address 0.
- Run while busy:
  - Stimulus: pulse pool_run mid-job.
  - Required: no effect; the output stream is identical to a run without the extra pulse.
